// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output channels of the instruction encoder.
// The encoder takes the slave side; the producer/consumer (loader, bench) takes master.
interface instr_encoder_if;
    // Input side: decoded instruction fields
    logic        IN_VALID;
    logic        IN_READY;
    logic [3:0]  INSTR_CLASS;
    logic [4:0]  ALU_OPCODE;
    logic [2:0]  FUNCT3_IN;
    logic [4:0]  RD;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic [31:0] IMM;

    // Output side: FIFO head
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] INSTRUCTION;
    logic [31:0] ADDRESS;
    logic        ILLEGAL;

    modport slave (
        input  IN_VALID, INSTR_CLASS, ALU_OPCODE, FUNCT3_IN, RD, RS1, RS2, IMM,
        output IN_READY,
        output OUT_VALID, INSTRUCTION, ADDRESS, ILLEGAL,
        input  OUT_READY
    );

    modport master (
        output IN_VALID, INSTR_CLASS, ALU_OPCODE, FUNCT3_IN, RD, RS1, RS2, IMM,
        input  IN_READY,
        input  OUT_VALID, INSTRUCTION, ADDRESS, ILLEGAL,
        output OUT_READY
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32IM instruction encoder: turns decoded field bundles back into 32-bit
// instruction words, tags each with its instruction-memory byte address and
// buffers the results in a 2-entry FIFO. Bad bundles become a NOP flagged ILLEGAL.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic           CLK,
    input  logic           RESET,
    instr_encoder_if.slave bus
);

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_IALU   = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_JAL    = 4'd4,
        CLS_JALR   = 4'd5,
        CLS_LUI    = 4'd6,
        CLS_AUIPC  = 4'd7,
        CLS_BRANCH = 4'd8
    } instr_class_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_ONE,
        FIFO_FULL
    } fifo_state_t;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    // ------------------------------------------------------------------
    // Immediate range checks
    // ------------------------------------------------------------------
    logic imm_i_ok;
    logic imm_sh_ok;
    logic imm_b_ok;
    logic imm_j_ok;
    logic imm_u_ok;

    assign imm_i_ok  = (&bus.IMM[31:11]) | ~(|bus.IMM[31:11]);
    assign imm_sh_ok = ~(|bus.IMM[31:5]);
    assign imm_b_ok  = ((&bus.IMM[31:12]) | ~(|bus.IMM[31:12])) & ~bus.IMM[0];
    assign imm_j_ok  = ((&bus.IMM[31:20]) | ~(|bus.IMM[31:20])) & ~bus.IMM[0];
    assign imm_u_ok  = ~(|bus.IMM[11:0]);

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [31:0] enc_word;
    logic        enc_bad;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [31:0] push_word;

    // Build the instruction word and flag any illegal class, code, funct3 or immediate
    always_comb begin
        enc_word = '0;
        enc_bad  = 1'b0;
        funct7   = '0;
        funct3   = '0;
        is_shift = 1'b0;
        case (bus.INSTR_CLASS)
            CLS_R: begin
                case (bus.ALU_OPCODE)
                    5'b00000: begin funct7 = 7'b0000000; funct3 = 3'b000; end // ADD
                    5'b00001: begin funct7 = 7'b0100000; funct3 = 3'b000; end // SUB
                    5'b00010: begin funct7 = 7'b0000000; funct3 = 3'b110; end // OR
                    5'b00011: begin funct7 = 7'b0000000; funct3 = 3'b100; end // XOR
                    5'b00100: begin funct7 = 7'b0000000; funct3 = 3'b111; end // AND
                    5'b00101: begin funct7 = 7'b0000000; funct3 = 3'b101; end // SRL
                    5'b00110: begin funct7 = 7'b0000000; funct3 = 3'b001; end // SLL
                    5'b00111: begin funct7 = 7'b0100000; funct3 = 3'b101; end // SRA
                    5'b01000: begin funct7 = 7'b0000001; funct3 = 3'b000; end // MUL
                    5'b01001: begin funct7 = 7'b0000001; funct3 = 3'b001; end // MULH
                    5'b01010: begin funct7 = 7'b0000001; funct3 = 3'b011; end // MULHU
                    5'b01011: begin funct7 = 7'b0000001; funct3 = 3'b010; end // MULHSU
                    5'b01100: begin funct7 = 7'b0000001; funct3 = 3'b100; end // DIV
                    5'b01101: begin funct7 = 7'b0000001; funct3 = 3'b101; end // DIVU
                    5'b01110: begin funct7 = 7'b0000001; funct3 = 3'b110; end // REM
                    5'b01111: begin funct7 = 7'b0000001; funct3 = 3'b111; end // REMU
                    5'b10000: begin funct7 = 7'b0000000; funct3 = 3'b010; end // SLT
                    default:  enc_bad = 1'b1;
                endcase
                enc_word = {funct7, bus.RS2, bus.RS1, funct3, bus.RD, OP_R};
            end
            CLS_IALU: begin
                case (bus.ALU_OPCODE)
                    5'b00000: funct3 = 3'b000;                                  // ADDI
                    5'b10000: funct3 = 3'b010;                                  // SLTI
                    5'b00100: funct3 = 3'b111;                                  // ANDI
                    5'b00010: funct3 = 3'b110;                                  // ORI
                    5'b00011: funct3 = 3'b100;                                  // XORI
                    5'b00110: begin funct3 = 3'b001; is_shift = 1'b1; end       // SLLI
                    5'b00101: begin funct3 = 3'b101; is_shift = 1'b1; end       // SRLI
                    5'b00111: begin funct3 = 3'b101; is_shift = 1'b1;
                                    funct7 = 7'b0100000; end                    // SRAI
                    default:  enc_bad = 1'b1;
                endcase
                if (is_shift) begin
                    enc_bad  = enc_bad | ~imm_sh_ok;
                    enc_word = {funct7, bus.IMM[4:0], bus.RS1, funct3, bus.RD, OP_IMM};
                end else begin
                    enc_bad  = enc_bad | ~imm_i_ok;
                    enc_word = {bus.IMM[11:0], bus.RS1, funct3, bus.RD, OP_IMM};
                end
            end
            CLS_LOAD: begin
                case (bus.FUNCT3_IN)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: enc_bad = ~imm_i_ok;
                    default:                                enc_bad = 1'b1;
                endcase
                enc_word = {bus.IMM[11:0], bus.RS1, bus.FUNCT3_IN, bus.RD, OP_LOAD};
            end
            CLS_STORE: begin
                case (bus.FUNCT3_IN)
                    3'b000, 3'b001, 3'b010: enc_bad = ~imm_i_ok;
                    default:                enc_bad = 1'b1;
                endcase
                enc_word = {bus.IMM[11:5], bus.RS2, bus.RS1, bus.FUNCT3_IN,
                            bus.IMM[4:0], OP_STORE};
            end
            CLS_BRANCH: begin
                case (bus.FUNCT3_IN)
                    3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111: enc_bad = ~imm_b_ok;
                    default:                                        enc_bad = 1'b1;
                endcase
                enc_word = {bus.IMM[12], bus.IMM[10:5], bus.RS2, bus.RS1, bus.FUNCT3_IN,
                            bus.IMM[4:1], bus.IMM[11], OP_BRANCH};
            end
            CLS_JAL: begin
                enc_bad  = ~imm_j_ok;
                enc_word = {bus.IMM[20], bus.IMM[10:1], bus.IMM[11], bus.IMM[19:12],
                            bus.RD, OP_JAL};
            end
            CLS_JALR: begin
                enc_bad  = ~imm_i_ok;
                enc_word = {bus.IMM[11:0], bus.RS1, 3'b000, bus.RD, OP_JALR};
            end
            CLS_LUI: begin
                enc_bad  = ~imm_u_ok;
                enc_word = {bus.IMM[31:12], bus.RD, OP_LUI};
            end
            CLS_AUIPC: begin
                enc_bad  = ~imm_u_ok;
                enc_word = {bus.IMM[31:12], bus.RD, OP_AUIPC};
            end
            default: enc_bad = 1'b1;
        endcase
    end

    assign push_word = enc_bad ? NOP_WORD : enc_word;

    // ------------------------------------------------------------------
    // Output FIFO: occupancy tracked as a small FSM
    // ------------------------------------------------------------------
    fifo_state_t state;
    fifo_state_t state_next;
    logic        in_ready;
    logic        out_valid;
    logic        push;
    logic        pop;

    logic [31:0] slot_word [2];
    logic [31:0] slot_addr [2];
    logic        slot_ill  [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [31:0] addr_cnt;

    assign in_ready  = (state != FIFO_FULL);
    assign out_valid = (state != FIFO_EMPTY);
    assign push      = bus.IN_VALID & in_ready;
    assign pop       = out_valid & bus.OUT_READY;

    // Occupancy state register
    always_ff @(posedge CLK) begin
        if (!RESET) state <= FIFO_EMPTY;
        else        state <= state_next;
    end

    // Occupancy next-state from push/pop; push and pop together at one entry keeps one
    always_comb begin
        state_next = state;
        case (state)
            FIFO_EMPTY: if (push) state_next = FIFO_ONE;
            FIFO_ONE: begin
                if (push && !pop)      state_next = FIFO_FULL;
                else if (pop && !push) state_next = FIFO_EMPTY;
            end
            FIFO_FULL:  if (pop) state_next = FIFO_ONE;
            default:    state_next = FIFO_EMPTY;
        endcase
    end

    // FIFO storage, pointers and address counter
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < 2; i++) begin
                slot_word[i] <= '0;
                slot_addr[i] <= '0;
                slot_ill[i]  <= 1'b0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            addr_cnt <= BASE_ADDR;
        end else begin
            if (push) begin
                slot_word[wr_ptr] <= push_word;
                slot_addr[wr_ptr] <= addr_cnt;
                slot_ill[wr_ptr]  <= enc_bad;
                wr_ptr            <= ~wr_ptr;
                addr_cnt          <= addr_cnt + ADDR_STEP;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

    // Head outputs, forced to zero while the FIFO is empty
    always_comb begin
        bus.IN_READY    = in_ready;
        bus.OUT_VALID   = out_valid;
        bus.INSTRUCTION = '0;
        bus.ADDRESS     = '0;
        bus.ILLEGAL     = 1'b0;
        if (out_valid) begin
            bus.INSTRUCTION = slot_word[rd_ptr];
            bus.ADDRESS     = slot_addr[rd_ptr];
            bus.ILLEGAL     = slot_ill[rd_ptr];
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the RV32IM control decode path. Accepts decoded instruction fields (class, ALU_OPCODE in the decoder's 5-bit encoding, register indices, immediate) over a valid/ready handshake.
- Produces the 32-bit RV32IM instruction word and its instruction-memory byte address.
- Buffers results in a 2-entry output FIFO.
- Used by the program loader and self-check benches to fill instruction memory, and for round-trip checks against the control unit.

Parameters:
- BASE_ADDR, 32'h00000000, byte address assigned to the first word after reset.
- ADDR_STEP, 4, byte increment per accepted word.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous reset, active-low
- IN_VALID  input  1  field bundle valid
- IN_READY  output  1  encoder can accept a bundle
- INSTR_CLASS  input  4  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=JAL, 5=JALR, 6=LUI, 7=AUIPC, 8=BRANCH; 9-15 illegal
- ALU_OPCODE  input  5  used by classes 0 and 1 only
- FUNCT3_IN  input  3  width/condition for LOAD, STORE, BRANCH
- RD, RS1, RS2  input  5 each  register indices
- IMM  input  32  full byte-offset or value immediate, sign-extended
- OUT_VALID  output  1  FIFO head valid
- OUT_READY  input  1  consumer accepts head
- INSTRUCTION  output  32  encoded word at FIFO head
- ADDRESS  output  32  byte address of head word
- ILLEGAL  output  1  head entry came from an illegal bundle

Behaviour:
- Reset when RESET=0 at a rising edge:
  - FIFO emptied; OUT_VALID=0, INSTRUCTION=0, ADDRESS=0, ILLEGAL=0.
  - Address counter set to BASE_ADDR; IN_READY=1 in the following cycle.
  - Reset overrides simultaneous push and pop; in-flight entries are discarded.
- Handshakes:
  - Push when IN_VALID&&IN_READY; pop when OUT_VALID&&OUT_READY.
  - IN_READY = (count<2), registered-state only, with no combinational path from OUT_READY.
  - IN_VALID while IN_READY=0 is ignored; no state change.
- Latency: a bundle accepted at edge N is at the head with OUT_VALID=1 after edge N when the FIFO was empty. Output is FIFO order.
- Simultaneous push and pop at count=1: count stays 1, head advances to the new entry.
- Pop at count=0 is impossible because OUT_VALID=0.
- INSTRUCTION, ADDRESS and ILLEGAL are held stable while OUT_VALID=1 and OUT_READY=0.
- Address counter:
  - Each pushed entry stores the current counter, which then increments by ADDR_STEP (modulo 2^32).
  - The counter advances for illegal entries too, so addresses stay contiguous.
- Encoding is combinational from the inputs and registered into the FIFO at push.
  - R, opcode 0110011:
    - 00000 ADD 0/000; 00001 SUB 0100000/000; 00010 OR 0/110; 00011 XOR 0/100; 00100 AND 0/111; 00101 SRL 0/101; 00110 SLL 0/001; 00111 SRA 0100000/101.
    - 01000 MUL 0000001/000; 01001 MULH 1/001; 01010 MULHU 1/011; 01011 MULHSU 1/010; 01100 DIV 1/100; 01101 DIVU 1/101; 01110 REM 1/110; 01111 REMU 1/111.
    - 10000 SLT 0/010.
    - Any other code is illegal.
  - I-ALU, opcode 0010011:
    - ADDI (00000, f3 000), SLTI (10000, f3 010), ANDI, ORI, XORI: imm[11:0]=IMM[11:0].
    - SLLI (00110) and SRLI (00101): funct7 0, shamt=IMM[4:0]. SRAI (00111): funct7 0100000, shamt=IMM[4:0].
    - Any other code is illegal.
  - LOAD, opcode 0000011: FUNCT3_IN must be in {000,001,010,100,101}.
  - STORE, opcode 0100011: FUNCT3_IN must be in {000,001,010}; S-split immediate.
  - BRANCH, opcode 1100011: FUNCT3_IN must be in {000,001,100,101,110,111}; B-split of IMM[12:1].
  - JAL, opcode 1101111: J-split of IMM[20:1].
  - JALR, opcode 1100111: funct3 forced to 000.
  - LUI 0110111 and AUIPC 0010111: upper field = IMM[31:12].
- Immediate range checks; any failure is illegal:
  - I, S, JALR: IMM[31:11] all equal.
  - Shifts: IMM[31:5]=0.
  - BRANCH: IMM[31:12] all equal and IMM[0]=0.
  - JAL: IMM[31:20] all equal and IMM[0]=0.
  - LUI, AUIPC: IMM[11:0]=0.
- Illegal bundle (illegal class, code, funct3 or immediate): stored as NOP 32'h00000013 with ILLEGAL=1. Never stalls or drops.

Test Plan:
- Reset low 2 cycles, then R ADD RD=3 RS1=1 RS2=2 -> one cycle later OUT_VALID=1, INSTRUCTION=0x002081B3, ADDRESS=0x00000000, ILLEGAL=0.
- Back-to-back pushes with OUT_READY=1: ADDI RD=1 RS1=0 IMM=-1; STORE f3=010 RS1=1 RS2=2 IMM=8 -> 0xFFF00093 @0x0, then 0x0020A423 @0x4.
- JAL RD=1 IMM=8 -> 0x008000EF. BRANCH f3=000 RS1=1 RS2=2 IMM=-4 -> 0xFE208EE3.
- OUT_READY=0, three pushes -> IN_READY=0 after the second push and the third is not accepted. Head held stable; release OUT_READY -> words emitted in order, addresses 0x0 and 0x4.
- Illegal bundles each -> 0x00000013, ILLEGAL=1, address still increments:
  - R with ALU_OPCODE=10001;
  - ADDI with IMM=0x800;
  - BRANCH with IMM=3.
- RESET=0 with 2 entries queued and push and pop asserted -> next cycle OUT_VALID=0, IN_READY=1. The next word gets address BASE_ADDR.
